// File: rtl/cpu86_mem_arbiter.sv
// Two-requester round-robin arbiter onto a single registered memory request channel.
// An in-order ID FIFO steers each read response back to the requester that issued it.
module cpu86_mem_arbiter #(
  parameter int REQ_W      = 64,
  parameter int RES_W      = 32,
  parameter int REQ_WR_BIT = 63,
  parameter int OUTST      = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             s0_req_tvalid,
  output logic             s0_req_tready,
  input  logic [REQ_W-1:0] s0_req_tdata,
  input  logic             s1_req_tvalid,
  output logic             s1_req_tready,
  input  logic [REQ_W-1:0] s1_req_tdata,
  output logic             m_req_tvalid,
  input  logic             m_req_tready,
  output logic [REQ_W-1:0] m_req_tdata,
  input  logic             s_res_tvalid,
  input  logic [RES_W-1:0] s_res_tdata,
  output logic             m0_res_tvalid,
  output logic [RES_W-1:0] m0_res_tdata,
  output logic             m1_res_tvalid,
  output logic [RES_W-1:0] m1_res_tdata,
  output logic             err_orphan
);

  localparam int AW = (OUTST > 1) ? $clog2(OUTST) : 1;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(OUTST);
  localparam logic [AW:0] ZERO_CNT = (AW+1)'(0);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  logic            id_mem_r [OUTST];
  logic [AW-1:0]   wr_ptr_r;
  logic [AW-1:0]   rd_ptr_r;
  logic [AW:0]     id_cnt_r;
  logic            prio_r;

  logic             slot_free_s;
  logic             wr0_s;
  logic             wr1_s;
  logic             room_s;
  logic             elig0_s;
  logic             elig1_s;
  logic             grant0_s;
  logic             grant1_s;
  logic [REQ_W-1:0] win_data_s;
  logic             push_s;
  logic             push_id_s;
  logic             pop_s;
  logic             orphan_s;
  logic             head_id_s;

  // Arbitration, FIFO push/pop decisions and response steering
  always_comb begin
    slot_free_s = !m_req_tvalid || m_req_tready;
    wr0_s       = s0_req_tdata[REQ_WR_BIT];
    wr1_s       = s1_req_tdata[REQ_WR_BIT];
    room_s      = (id_cnt_r < FULL_CNT);
    elig0_s     = s0_req_tvalid && (wr0_s || room_s);
    elig1_s     = s1_req_tvalid && (wr1_s || room_s);
    grant0_s    = 1'b0;
    grant1_s    = 1'b0;
    // prio_r = 1 means requester 1 wins a tie
    if (!reset && slot_free_s) begin
      grant0_s = elig0_s && (!elig1_s || !prio_r);
      grant1_s = elig1_s && (!elig0_s || prio_r);
    end else begin
      grant0_s = 1'b0;
      grant1_s = 1'b0;
    end
    if (grant1_s) begin
      win_data_s = s1_req_tdata;
    end else begin
      win_data_s = s0_req_tdata;
    end
    push_s    = (grant0_s && !wr0_s) || (grant1_s && !wr1_s);
    push_id_s = grant1_s;
    // An empty FIFO with a same-cycle push forwards the pushed id straight to the head
    pop_s     = s_res_tvalid && ((id_cnt_r != ZERO_CNT) || push_s);
    orphan_s  = s_res_tvalid && !pop_s;
    if (id_cnt_r == ZERO_CNT) begin
      head_id_s = push_id_s;
    end else begin
      head_id_s = id_mem_r[rd_ptr_r];
    end
  end

  assign s0_req_tready = grant0_s;
  assign s1_req_tready = grant1_s;

  // Request register, ID FIFO state and response outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      m_req_tvalid  <= 1'b0;
      m_req_tdata   <= {REQ_W{1'b0}};
      prio_r        <= 1'b0;
      wr_ptr_r      <= {AW{1'b0}};
      rd_ptr_r      <= {AW{1'b0}};
      id_cnt_r      <= ZERO_CNT;
      m0_res_tvalid <= 1'b0;
      m0_res_tdata  <= {RES_W{1'b0}};
      m1_res_tvalid <= 1'b0;
      m1_res_tdata  <= {RES_W{1'b0}};
      err_orphan    <= 1'b0;
      for (int i = 0; i < OUTST; i++) begin
        id_mem_r[i] <= 1'b0;
      end
    end else begin
      if (grant0_s || grant1_s) begin
        m_req_tvalid <= 1'b1;
        m_req_tdata  <= win_data_s;
        prio_r       <= grant0_s;
      end else if (m_req_tready) begin
        m_req_tvalid <= 1'b0;
      end
      if (push_s) begin
        id_mem_r[wr_ptr_r] <= push_id_s;
        wr_ptr_r           <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({push_s, pop_s})
        2'b10:   id_cnt_r <= id_cnt_r + (AW+1)'(1);
        2'b01:   id_cnt_r <= id_cnt_r - (AW+1)'(1);
        default: id_cnt_r <= id_cnt_r;
      endcase
      m0_res_tvalid <= pop_s && !head_id_s;
      m1_res_tvalid <= pop_s && head_id_s;
      if (pop_s && !head_id_s) begin
        m0_res_tdata <= s_res_tdata;
      end
      if (pop_s && head_id_s) begin
        m1_res_tdata <= s_res_tdata;
      end
      if (orphan_s) begin
        err_orphan <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cpu86_mem_arbiter.sv
// Directed self-checking bench for cpu86_mem_arbiter: arbitration, ID routing, full stall,
// backpressure, orphan responses and reset in mid-operation.
module tb_cpu86_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        s0_req_tvalid, s0_req_tready;
  logic [63:0] s0_req_tdata;
  logic        s1_req_tvalid, s1_req_tready;
  logic [63:0] s1_req_tdata;
  logic        m_req_tvalid, m_req_tready;
  logic [63:0] m_req_tdata;
  logic        s_res_tvalid;
  logic [31:0] s_res_tdata;
  logic        m0_res_tvalid, m1_res_tvalid;
  logic [31:0] m0_res_tdata, m1_res_tdata;
  logic        err_orphan;

  int n_cmp = 0;
  int n_bad = 0;

  cpu86_mem_arbiter dut (
    .clk(clk), .reset(reset),
    .s0_req_tvalid(s0_req_tvalid), .s0_req_tready(s0_req_tready), .s0_req_tdata(s0_req_tdata),
    .s1_req_tvalid(s1_req_tvalid), .s1_req_tready(s1_req_tready), .s1_req_tdata(s1_req_tdata),
    .m_req_tvalid(m_req_tvalid), .m_req_tready(m_req_tready), .m_req_tdata(m_req_tdata),
    .s_res_tvalid(s_res_tvalid), .s_res_tdata(s_res_tdata),
    .m0_res_tvalid(m0_res_tvalid), .m0_res_tdata(m0_res_tdata),
    .m1_res_tvalid(m1_res_tvalid), .m1_res_tdata(m1_res_tdata),
    .err_orphan(err_orphan)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    s0_req_tvalid = 1'b0; s0_req_tdata = 64'h0;
    s1_req_tvalid = 1'b0; s1_req_tdata = 64'h0;
    m_req_tready  = 1'b1;
    s_res_tvalid  = 1'b0; s_res_tdata = 32'h0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    s0_req_tvalid = 1'b1;
    s1_req_tvalid = 1'b1;
    tick();
    tick();
    #3;
    n_cmp++;
    if ({s0_req_tready, s1_req_tready} !== 2'b00) begin
      n_bad++; $display("FAIL reset_ready: got %b want 00", {s0_req_tready, s1_req_tready});
    end
    n_cmp++;
    if ({m_req_tvalid, m0_res_tvalid, m1_res_tvalid, err_orphan} !== 4'b0000 ||
        m_req_tdata !== 64'h0 || m0_res_tdata !== 32'h0 || m1_res_tdata !== 32'h0) begin
      n_bad++; $display("FAIL reset_outputs: got v=%b%b%b e=%b d=%h/%h/%h want all zero",
        m_req_tvalid, m0_res_tvalid, m1_res_tvalid, err_orphan, m_req_tdata, m0_res_tdata, m1_res_tdata);
    end
    reset = 1'b0;
    idle_inputs();
    tick();
  endtask

  task automatic test_s0_reads();
    logic saw_m1;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      s0_req_tvalid = 1'b1;
      s0_req_tdata  = 64'h0000_0000_0000_0100 + 64'(i);
      #3;
      n_cmp++;
      if (s0_req_tready !== 1'b1) begin
        n_bad++; $display("FAIL s0_read_ready[%0d]: got %b want 1", i, s0_req_tready);
      end
      tick();
      n_cmp++;
      if (m_req_tvalid !== 1'b1 || m_req_tdata !== 64'h0000_0000_0000_0100 + 64'(i)) begin
        n_bad++; $display("FAIL s0_read_req[%0d]: got v=%b d=%h want v=1 d=%h",
          i, m_req_tvalid, m_req_tdata, 64'h0000_0000_0000_0100 + 64'(i));
      end
    end
    s0_req_tvalid = 1'b0;
    saw_m1 = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      s_res_tvalid = 1'b1;
      s_res_tdata  = 32'hAAAA_0000 + 32'(i);
      tick();
      s_res_tvalid = 1'b0;
      if (m1_res_tvalid !== 1'b0) saw_m1 = 1'b1;
      n_cmp++;
      if (m0_res_tvalid !== 1'b1 || m0_res_tdata !== 32'hAAAA_0000 + 32'(i)) begin
        n_bad++; $display("FAIL s0_read_res[%0d]: got v=%b d=%h want v=1 d=%h",
          i, m0_res_tvalid, m0_res_tdata, 32'hAAAA_0000 + 32'(i));
      end
    end
    tick();
    if (m1_res_tvalid !== 1'b0) saw_m1 = 1'b1;
    n_cmp++;
    if (m0_res_tvalid !== 1'b0 || saw_m1 !== 1'b0 || err_orphan !== 1'b0) begin
      n_bad++; $display("FAIL s0_read_tail: got m0v=%b m1_seen=%b err=%b want 0 0 0",
        m0_res_tvalid, saw_m1, err_orphan);
    end
  endtask

  task automatic test_alternate();
    logic [3:0] exp_win;
    exp_win = 4'b1010;
    do_reset();
    s0_req_tvalid = 1'b1; s0_req_tdata = 64'h0000_0000_0000_0010;
    s1_req_tvalid = 1'b1; s1_req_tdata = 64'h0000_0000_0000_0020;
    for (int i = 0; i < 4; i++) begin
      #3;
      n_cmp++;
      if (s0_req_tready !== !exp_win[i] || s1_req_tready !== exp_win[i]) begin
        n_bad++; $display("FAIL alt_grant[%0d]: got r0=%b r1=%b want winner %0d",
          i, s0_req_tready, s1_req_tready, exp_win[i]);
      end
      tick();
      n_cmp++;
      if (m_req_tdata !== (exp_win[i] ? 64'h20 : 64'h10)) begin
        n_bad++; $display("FAIL alt_req[%0d]: got %h want %h", i, m_req_tdata, exp_win[i] ? 64'h20 : 64'h10);
      end
    end
    s0_req_tvalid = 1'b0;
    s1_req_tvalid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      s_res_tvalid = 1'b1;
      s_res_tdata  = 32'hBBBB_0000 + 32'(i);
      tick();
      s_res_tvalid = 1'b0;
      n_cmp++;
      if (m0_res_tvalid !== !exp_win[i] || m1_res_tvalid !== exp_win[i] ||
          (exp_win[i] ? m1_res_tdata : m0_res_tdata) !== 32'hBBBB_0000 + 32'(i)) begin
        n_bad++; $display("FAIL alt_res[%0d]: got v0=%b v1=%b d0=%h d1=%h want port %0d d=%h",
          i, m0_res_tvalid, m1_res_tvalid, m0_res_tdata, m1_res_tdata, exp_win[i], 32'hBBBB_0000 + 32'(i));
      end
    end
  endtask

  task automatic test_full();
    int n_grant;
    do_reset();
    n_grant = 0;
    s1_req_tvalid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      s1_req_tdata = 64'h0000_0000_0000_0300 + 64'(i);
      #3;
      if (s1_req_tready === 1'b1) n_grant++;
      tick();
    end
    n_cmp++;
    if (n_grant !== 8) begin
      n_bad++; $display("FAIL full_fill: got %0d grants want 8", n_grant);
    end
    s1_req_tdata = 64'h0000_0000_0000_0400;
    #3;
    n_cmp++;
    if (s1_req_tready !== 1'b0) begin
      n_bad++; $display("FAIL full_read_stall: got ready=%b want 0", s1_req_tready);
    end
    tick();
    s1_req_tdata = 64'h8000_0000_0000_0555;
    #3;
    n_cmp++;
    if (s1_req_tready !== 1'b1) begin
      n_bad++; $display("FAIL full_write_pass: got ready=%b want 1", s1_req_tready);
    end
    tick();
    n_cmp++;
    if (m_req_tdata !== 64'h8000_0000_0000_0555) begin
      n_bad++; $display("FAIL full_write_req: got %h want 8000000000000555", m_req_tdata);
    end
    s1_req_tdata = 64'h0000_0000_0000_0400;
    s_res_tvalid = 1'b1;
    s_res_tdata  = 32'h1111_2222;
    #3;
    n_cmp++;
    if (s1_req_tready !== 1'b0) begin
      n_bad++; $display("FAIL full_same_cycle_pop: got ready=%b want 0", s1_req_tready);
    end
    tick();
    s_res_tvalid = 1'b0;
    n_cmp++;
    if (m1_res_tvalid !== 1'b1 || m1_res_tdata !== 32'h1111_2222 || m0_res_tvalid !== 1'b0) begin
      n_bad++; $display("FAIL full_res: got v1=%b d1=%h v0=%b want 1 11112222 0",
        m1_res_tvalid, m1_res_tdata, m0_res_tvalid);
    end
    #3;
    n_cmp++;
    if (s1_req_tready !== 1'b1) begin
      n_bad++; $display("FAIL full_unstall: got ready=%b want 1", s1_req_tready);
    end
    tick();
    s1_req_tvalid = 1'b0;
    n_cmp++;
    if (m_req_tdata !== 64'h0000_0000_0000_0400) begin
      n_bad++; $display("FAIL full_unstall_req: got %h want 0000000000000400", m_req_tdata);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    m_req_tready  = 1'b0;
    s0_req_tvalid = 1'b1;
    s0_req_tdata  = 64'h8000_0000_0000_00A1;
    tick();
    s0_req_tdata  = 64'h8000_0000_0000_00A2;
    for (int i = 0; i < 5; i++) begin
      #3;
      n_cmp++;
      if (s0_req_tready !== 1'b0 || m_req_tvalid !== 1'b1 || m_req_tdata !== 64'h8000_0000_0000_00A1) begin
        n_bad++; $display("FAIL bp_hold[%0d]: got r=%b v=%b d=%h want 0 1 80000000000000a1",
          i, s0_req_tready, m_req_tvalid, m_req_tdata);
      end
      tick();
    end
    m_req_tready = 1'b1;
    #3;
    n_cmp++;
    if (s0_req_tready !== 1'b1) begin
      n_bad++; $display("FAIL bp_release_grant: got ready=%b want 1", s0_req_tready);
    end
    tick();
    s0_req_tvalid = 1'b0;
    n_cmp++;
    if (m_req_tvalid !== 1'b1 || m_req_tdata !== 64'h8000_0000_0000_00A2) begin
      n_bad++; $display("FAIL bp_next_req: got v=%b d=%h want 1 80000000000000a2", m_req_tvalid, m_req_tdata);
    end
    tick();
    n_cmp++;
    if (m_req_tvalid !== 1'b0) begin
      n_bad++; $display("FAIL bp_drain: got v=%b want 0", m_req_tvalid);
    end
  endtask

  task automatic test_orphan();
    do_reset();
    s_res_tvalid = 1'b1;
    s_res_tdata  = 32'hDEAD_BEEF;
    tick();
    s_res_tvalid = 1'b0;
    n_cmp++;
    if (m0_res_tvalid !== 1'b0 || m1_res_tvalid !== 1'b0 || err_orphan !== 1'b1) begin
      n_bad++; $display("FAIL orphan_flag: got v0=%b v1=%b err=%b want 0 0 1",
        m0_res_tvalid, m1_res_tvalid, err_orphan);
    end
    tick();
    tick();
    n_cmp++;
    if (err_orphan !== 1'b1) begin
      n_bad++; $display("FAIL orphan_sticky: got %b want 1", err_orphan);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_cmp++;
    if (err_orphan !== 1'b0) begin
      n_bad++; $display("FAIL orphan_clear: got %b want 0", err_orphan);
    end
    // Empty FIFO with a push and a response in the same cycle is not an orphan
    s1_req_tvalid = 1'b1;
    s1_req_tdata  = 64'h0000_0000_0000_0777;
    s_res_tvalid  = 1'b1;
    s_res_tdata   = 32'h7777_0001;
    tick();
    s1_req_tvalid = 1'b0;
    s_res_tvalid  = 1'b0;
    n_cmp++;
    if (m1_res_tvalid !== 1'b1 || m1_res_tdata !== 32'h7777_0001 || err_orphan !== 1'b0) begin
      n_bad++; $display("FAIL empty_push_pop: got v1=%b d1=%h err=%b want 1 77770001 0",
        m1_res_tvalid, m1_res_tdata, err_orphan);
    end
  endtask

  task automatic test_reset_midop();
    do_reset();
    s0_req_tvalid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      s0_req_tdata = 64'h0000_0000_0000_0900 + 64'(i);
      tick();
    end
    s0_req_tvalid = 1'b0;
    m_req_tready  = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    m_req_tready = 1'b1;
    n_cmp++;
    if (m_req_tvalid !== 1'b0 || m_req_tdata !== 64'h0 || m0_res_tvalid !== 1'b0 ||
        m1_res_tvalid !== 1'b0 || err_orphan !== 1'b0) begin
      n_bad++; $display("FAIL midop_reset: got v=%b d=%h v0=%b v1=%b err=%b want all zero",
        m_req_tvalid, m_req_tdata, m0_res_tvalid, m1_res_tvalid, err_orphan);
    end
    s_res_tvalid = 1'b1;
    s_res_tdata  = 32'h0BAD_0001;
    tick();
    s_res_tvalid = 1'b0;
    n_cmp++;
    if (m0_res_tvalid !== 1'b0 || err_orphan !== 1'b1) begin
      n_bad++; $display("FAIL midop_late_res: got v0=%b err=%b want 0 1", m0_res_tvalid, err_orphan);
    end
    s1_req_tvalid = 1'b1;
    s1_req_tdata  = 64'h0000_0000_0000_0A01;
    tick();
    s1_req_tvalid = 1'b0;
    n_cmp++;
    if (m_req_tvalid !== 1'b1 || m_req_tdata !== 64'h0000_0000_0000_0A01) begin
      n_bad++; $display("FAIL midop_fresh_req: got v=%b d=%h want 1 0000000000000a01", m_req_tvalid, m_req_tdata);
    end
    s_res_tvalid = 1'b1;
    s_res_tdata  = 32'hCCCC_0001;
    tick();
    s_res_tvalid = 1'b0;
    n_cmp++;
    if (m1_res_tvalid !== 1'b1 || m1_res_tdata !== 32'hCCCC_0001 || m0_res_tvalid !== 1'b0 ||
        m0_res_tdata !== 32'h0) begin
      n_bad++; $display("FAIL midop_fresh_res: got v1=%b d1=%h v0=%b d0=%h want 1 cccc0001 0 0",
        m1_res_tvalid, m1_res_tdata, m0_res_tvalid, m0_res_tdata);
    end
  endtask

  initial begin
    idle_inputs();
    reset = 1'b1;
    test_reset();
    test_s0_reads();
    test_alternate();
    test_full();
    test_backpressure();
    test_orphan();
    test_reset_midop();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
